// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: PC width, FSM states,
// redirect priorities and the pending-redirect record.
package fetch_pkg;

  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] DEFAULT_LOADER_ADDR = 32'hF000_0000;
  localparam logic [PC_WIDTH-1:0] DEFAULT_EXC_VECTOR  = 32'h8000_0180;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  // Numeric order is the arbitration order: larger value wins.
  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_BR   = 2'd1,
    PRIO_ERET = 2'd2,
    PRIO_EXC  = 2'd3
  } redir_prio_e;

  typedef struct packed {
    logic                valid;
    redir_prio_e         prio;
    logic [PC_WIDTH-1:0] target;
  } redir_t;

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the core pipeline / imem and the fetch sequencer.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic [PC_WIDTH-1:0] pc_cur;
  logic                stall_in;
  logic                imem_ready;
  logic                br_valid;
  logic [PC_WIDTH-1:0] br_target;
  logic                exc_valid;
  logic                eret_valid;
  logic [PC_WIDTH-1:0] eret_target;
  logic [PC_WIDTH-1:0] pc_next;
  logic                pc_stall;
  logic                fetch_req;
  logic                flush;
  logic [1:0]          state_o;

  modport master (
    output pc_cur, stall_in, imem_ready, br_valid, br_target,
           exc_valid, eret_valid, eret_target,
    input  pc_next, pc_stall, fetch_req, flush, state_o
  );

  modport slave (
    input  pc_cur, stall_in, imem_ready, br_valid, br_target,
           exc_valid, eret_valid, eret_target,
    output pc_next, pc_stall, fetch_req, flush, state_o
  );

endinterface

// File: rtl/fetch_sequencer_redirect_arb.sv
// Combinational redirect arbiter: picks the strongest of this cycle's requests
// and the pending redirect. A new request replaces pending at equal or higher priority.
module redirect_arb
  import fetch_pkg::*;
(
  input  logic                exc_valid,
  input  logic [PC_WIDTH-1:0] exc_target,
  input  logic                eret_valid,
  input  logic [PC_WIDTH-1:0] eret_target,
  input  logic                br_valid,
  input  logic [PC_WIDTH-1:0] br_target,
  input  redir_t              pend,
  output redir_t              win,
  output logic                win_is_new
);

  redir_t new_req;

  always_comb begin
    new_req = '0;
    if (exc_valid) begin
      new_req = '{valid: 1'b1, prio: PRIO_EXC, target: exc_target};
    end else if (eret_valid) begin
      new_req = '{valid: 1'b1, prio: PRIO_ERET, target: eret_target};
    end else if (br_valid) begin
      new_req = '{valid: 1'b1, prio: PRIO_BR, target: br_target};
    end
  end

  always_comb begin
    win        = pend;
    win_is_new = 1'b0;
    if (new_req.valid && (!pend.valid || new_req.prio >= pend.prio)) begin
      win        = new_req;
      win_is_new = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer: BOOT/FETCH/STALL FSM plus a single pending-redirect register.
// Build option FETCH_DELAY_SLOT_EN: branches take one delay-slot fetch and never flush.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] LOADER_ADDR = DEFAULT_LOADER_ADDR,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR  = DEFAULT_EXC_VECTOR
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  fetch_state_e        state_q, state_d;
  redir_t              pend_q, pend_d;
  redir_t              win;
  logic                win_is_new;
  logic                stall_c;
  logic                defer;
  logic [PC_WIDTH-1:0] pc_inc;
`ifdef FETCH_DELAY_SLOT_EN
  logic                slot_q, slot_d;
`endif

  redirect_arb u_arb (
    .exc_valid   (bus.exc_valid),
    .exc_target  (EXC_VECTOR),
    .eret_valid  (bus.eret_valid),
    .eret_target (bus.eret_target),
    .br_valid    (bus.br_valid),
    .br_target   (bus.br_target),
    .pend        (pend_q),
    .win         (win),
    .win_is_new  (win_is_new)
  );

  assign stall_c = bus.stall_in | ~bus.imem_ready;
  assign pc_inc  = word_align(bus.pc_cur + 32'd4);

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    defer         = 1'b0;
    bus.pc_next   = LOADER_ADDR;
    bus.pc_stall  = 1'b1;
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    bus.state_o   = reset ? ST_BOOT : state_q;
`ifdef FETCH_DELAY_SLOT_EN
    slot_d        = slot_q;
    // A branch waits in pending until one delay-slot advance has passed.
    defer = win.valid && (win.prio == PRIO_BR) && (win_is_new || slot_q);
`endif

    if (reset) begin
      state_d = ST_BOOT;
    end else if (state_q == ST_BOOT) begin
      state_d = ST_FETCH;
    end else begin
      bus.fetch_req = 1'b1;
      bus.pc_stall  = stall_c;
      bus.pc_next   = pc_inc;
      state_d       = stall_c ? ST_STALL : ST_FETCH;
      if (defer) begin
        pend_d = win;
`ifdef FETCH_DELAY_SLOT_EN
        slot_d = stall_c;
`endif
      end else if (win.valid) begin
        if (stall_c) begin
          pend_d = win;
`ifdef FETCH_DELAY_SLOT_EN
          slot_d = 1'b0;
`endif
        end else begin
          bus.pc_next = word_align(win.target);
`ifdef FETCH_DELAY_SLOT_EN
          bus.flush   = (win.prio != PRIO_BR);
          slot_d      = 1'b0;
`else
          bus.flush   = 1'b1;
`endif
          pend_d      = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef FETCH_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench: the driver queues expected outputs per cycle, the monitor
// pops and compares them on the falling edge.
module tb_fetch_sequencer;

  typedef struct {
    logic        chk_pc;
    logic [31:0] pc;
    logic        flush;
    logic        freq;
    logic        stall;
    logic [1:0]  state;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  fetch_sequencer_if bus();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic [31:0] pc, input logic stall,
                       input logic ready, input logic br, input logic [31:0] bt,
                       input logic exc, input logic eret, input logic [31:0] et);
    reset          = rst;
    bus.pc_cur     = pc;
    bus.stall_in   = stall;
    bus.imem_ready = ready;
    bus.br_valid   = br;
    bus.br_target  = bt;
    bus.exc_valid  = exc;
    bus.eret_valid = eret;
    bus.eret_target = et;
  endtask

  task automatic expect_cyc(input string name, input logic chk_pc, input logic [31:0] pc,
                            input logic flush, input logic freq, input logic stall,
                            input logic [1:0] state);
    exp_t e;
    e.name = name; e.chk_pc = chk_pc; e.pc = pc; e.flush = flush;
    e.freq = freq; e.stall = stall; e.state = state;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  // Monitor: one compare set per cycle with a queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.chk_pc) cmp(e.name, "pc_next", bus.pc_next, e.pc);
      cmp(e.name, "flush", {31'd0, bus.flush}, {31'd0, e.flush});
      cmp(e.name, "fetch_req", {31'd0, bus.fetch_req}, {31'd0, e.freq});
      cmp(e.name, "pc_stall", {31'd0, bus.pc_stall}, {31'd0, e.stall});
      cmp(e.name, "state_o", {30'd0, bus.state_o}, {30'd0, e.state});
      $display("txn %-14s pc_next=%h flush=%b fetch_req=%b pc_stall=%b state=%0d",
               e.name, bus.pc_next, bus.flush, bus.fetch_req, bus.pc_stall, bus.state_o);
    end
  end

  localparam logic [31:0] LDR = 32'hF000_0000;
  localparam logic [31:0] EXC = 32'h8000_0180;

  initial begin
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    // Reset and boot
    expect_cyc("reset", 1'b1, LDR, 1'b0, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 32'h100, 1'b0, 1'b1, 1'b1, 32'h5000, 1'b0, 1'b0, 32'h0);
    expect_cyc("boot_br_ign", 1'b1, LDR, 1'b0, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("fetch_inc", 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 2'd1);
    // Unstalled branch
    drive(1'b0, 32'h1000, 1'b0, 1'b1, 1'b1, 32'h2002, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_DELAY_SLOT_EN
    expect_cyc("br_slot", 1'b1, 32'h1004, 1'b0, 1'b1, 1'b0, 2'd1);
    drive(1'b0, 32'h1004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("br_apply", 1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 2'd1);
`else
    expect_cyc("br_now", 1'b1, 32'h2000, 1'b1, 1'b1, 1'b0, 2'd1);
    drive(1'b0, 32'h2000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("after_br", 1'b1, 32'h2004, 1'b0, 1'b1, 1'b0, 2'd1);
`endif
    // Priority
    drive(1'b0, 32'h2000, 1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 1'b0, 32'h0);
    expect_cyc("exc_over_br", 1'b1, EXC, 1'b1, 1'b1, 1'b0, 2'd1);
    drive(1'b0, 32'h2000, 1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b1, 32'h4001);
    expect_cyc("eret_over_br", 1'b1, 32'h4000, 1'b1, 1'b1, 1'b0, 2'd1);
    // Wrap
    drive(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("wrap", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1);
    // Stall: branch then exception latched, applied on release
    drive(1'b0, 32'h500, 1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    expect_cyc("stl_br", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd1);
    drive(1'b0, 32'h500, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    expect_cyc("stl_exc", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd2);
    drive(1'b0, 32'h500, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("stl_idle", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd2);
    drive(1'b0, 32'h500, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("stl_release", 1'b1, EXC, 1'b1, 1'b1, 1'b0, 2'd2);
    drive(1'b0, EXC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("pend_cleared", 1'b1, 32'h8000_0184, 1'b0, 1'b1, 1'b0, 2'd1);
    // imem not ready: pending eret beats simultaneous branch on release
    drive(1'b0, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600);
    expect_cyc("imem_wait", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd1);
    drive(1'b0, 32'h500, 1'b0, 1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
    expect_cyc("pend_vs_br", 1'b1, 32'h600, 1'b1, 1'b1, 1'b0, 2'd2);
    drive(1'b0, 32'h600, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("br_dropped", 1'b1, 32'h604, 1'b0, 1'b1, 1'b0, 2'd1);
    // Overwrite rules while stalled
    drive(1'b0, 32'h800, 1'b1, 1'b1, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0);
    expect_cyc("ow_br", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd1);
    drive(1'b0, 32'h800, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA00);
    expect_cyc("ow_eret_hi", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd2);
    drive(1'b0, 32'h800, 1'b1, 1'b1, 1'b1, 32'hB00, 1'b0, 1'b0, 32'h0);
    expect_cyc("ow_br_lo", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd2);
    drive(1'b0, 32'h800, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC00);
    expect_cyc("ow_eret_eq", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd2);
    drive(1'b0, 32'h800, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("ow_release", 1'b1, 32'hC00, 1'b1, 1'b1, 1'b0, 2'd2);
    // Reset discards a pending branch
    drive(1'b0, 32'h900, 1'b1, 1'b1, 1'b1, 32'hD00, 1'b0, 1'b0, 32'h0);
    expect_cyc("rst_pend_br", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd1);
    drive(1'b1, 32'h900, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("rst_assert", 1'b1, LDR, 1'b0, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expect_cyc("rst_boot", 1'b1, LDR, 1'b0, 1'b0, 1'b1, 2'd0);
    expect_cyc("rst_no_target", 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 2'd1);
    expect_cyc("rst_no_target2", 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 2'd1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0 entries left", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
